// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Holds the arbiter state encoding and the default starvation limit.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DBG_ACC = 2'd1,
        DBG_ACK = 2'd2
    } arb_state_e;

    localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of IDLE cycles in which debug is blocked by the CPU.
// sat_o asserts once the count equals LIMIT; clr_i has priority.
module dmem_arb_starve_ctr #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic clrn,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [7:0] LIM = 8'(LIMIT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Clear on grant, otherwise count blocked cycles up to the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (inc_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the MEM stage and a debug master.
// Optional starvation guard enabled by macro DMEM_ARB_STARVE_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int A_WIDTH      = 14
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_stall,
    input  logic               dbg_req,
    input  logic               dbg_we,
    input  logic [31:0]        dbg_addr,
    input  logic [31:0]        dbg_wdata,
    output logic [31:0]        dbg_rdata,
    output logic               dbg_ack,
    output logic               mem_cs,
    output logic               mem_we,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    arb_state_e  state_q;
    arb_state_e  state_d;
    logic [31:0] dbg_rdata_q;
    logic        starve_hit;
    logic        unused_addr;

    assign unused_addr = ^{cpu_addr[31:A_WIDTH+2], cpu_addr[1:0],
                           dbg_addr[31:A_WIDTH+2], dbg_addr[1:0]};

`ifdef DMEM_ARB_STARVE_EN
    logic ctr_inc;
    logic ctr_clr;

    assign ctr_inc = (state_q == IDLE) && dbg_req && cpu_req;
    assign ctr_clr = (state_q == IDLE) && (state_d == DBG_ACC);

    dmem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk   (clk),
        .clrn  (clrn),
        .inc_i (ctr_inc),
        .clr_i (ctr_clr),
        .sat_o (starve_hit)
    );
`else
    logic unused_lim;

    assign unused_lim = (STARVE_LIMIT > 0);
    assign starve_hit = 1'b0;
`endif

    // Next state: CPU keeps the port unless idle or starvation forces debug.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dbg_req && (!cpu_req || starve_hit)) begin
                    state_d = DBG_ACC;
                end
            end
            DBG_ACC: state_d = DBG_ACK;
            DBG_ACK: begin
                if (!dbg_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port mux: CPU by default, debug during the access cycle, quiet in reset.
    always_comb begin
        mem_cs    = cpu_req;
        mem_we    = cpu_req & cpu_we;
        mem_addr  = cpu_addr[A_WIDTH+1:2];
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
        cpu_stall = 1'b0;
        if (state_q == DBG_ACC) begin
            mem_cs    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr[A_WIDTH+1:2];
            mem_wdata = dbg_wdata;
            cpu_rdata = 32'd0;
            cpu_stall = cpu_req;
        end
        if (!clrn) begin
            mem_cs    = 1'b0;
            mem_we    = 1'b0;
            cpu_stall = 1'b0;
        end
    end

    // State register; reset aborts any debug access in flight.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Debug read data captured at the end of the access cycle.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            dbg_rdata_q <= 32'd0;
        end else if (state_q == DBG_ACC) begin
            dbg_rdata_q <= mem_rdata;
        end
    end

    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = (state_q == DBG_ACK);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter against a transaction-level model.
// Works with and without DMEM_ARB_STARVE_EN.
module tb_dmem_arbiter;

    localparam int LIM = 4;
    localparam int AW  = 14;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic          clk;
    logic          clrn;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req;
    logic          dbg_we;
    logic [31:0]   dbg_addr;
    logic [31:0]   dbg_wdata;
    logic [31:0]   dbg_rdata;
    logic          dbg_ack;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    dmem_arbiter #(
        .STARVE_LIMIT (LIM),
        .A_WIDTH      (AW)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ack   (dbg_ack),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency RAM driven by the DUT command port.
    logic [31:0] ram [0:(1<<AW)-1];
    logic        fill;

    assign mem_rdata = ram[mem_addr];

    // RAM write port; first edge zero-fills the array.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= 32'd0;
        end else if (mem_cs && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    // Reference model: memory contents plus debug transaction progress.
    logic [31:0] ref_mem [0:(1<<AW)-1];
    bit          m_acc;
    bit          m_ack;
    int          m_wait;
    logic [31:0] m_rdata;
    int          n_chk;
    int          n_pass;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
    endtask

    task automatic set_cpu(input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
    endtask

    // Mid-cycle comparison of every output against the model.
    task automatic settle();
        logic [13:0] ca;
        logic [13:0] da;
        #4;
        ca = cpu_addr[15:2];
        da = dbg_addr[15:2];
        if (!clrn) begin
            chk("rst_cs", 32'(mem_cs), 32'd0);
            chk("rst_we", 32'(mem_we), 32'd0);
            chk("rst_stall", 32'(cpu_stall), 32'd0);
        end else if (m_acc) begin
            chk("acc_cs", 32'(mem_cs), 32'd1);
            chk("acc_we", 32'(mem_we), 32'(dbg_we));
            chk("acc_addr", 32'(mem_addr), 32'(da));
            chk("acc_wdata", mem_wdata, dbg_wdata);
            chk("acc_stall", 32'(cpu_stall), 32'(cpu_req));
            chk("acc_rdata", cpu_rdata, 32'd0);
            chk("acc_ack", 32'(dbg_ack), 32'd0);
        end else begin
            chk("cpu_cs", 32'(mem_cs), 32'(cpu_req));
            chk("cpu_we", 32'(mem_we), 32'(cpu_req & cpu_we));
            chk("cpu_addr", 32'(mem_addr), 32'(ca));
            chk("cpu_wdata", mem_wdata, cpu_wdata);
            chk("cpu_rdata", cpu_rdata, ref_mem[ca]);
            chk("cpu_stall", 32'(cpu_stall), 32'd0);
            chk("dbg_ack", 32'(dbg_ack), 32'(m_ack));
            if (m_ack) chk("dbg_rdata", dbg_rdata, m_rdata);
        end
    endtask

    // Advance the model by one clock using the current inputs.
    task automatic tick();
        logic [13:0] ca;
        logic [13:0] da;
        ca = cpu_addr[15:2];
        da = dbg_addr[15:2];
        if (!clrn) begin
            m_acc = 0; m_ack = 0; m_wait = 0; m_rdata = 32'd0;
        end else if (m_acc) begin
            m_rdata = ref_mem[da];
            if (dbg_we) ref_mem[da] = dbg_wdata;
            m_acc = 0;
            m_ack = 1;
        end else begin
            if (cpu_req && cpu_we) ref_mem[ca] = cpu_wdata;
            if (m_ack) begin
                if (!dbg_req) m_ack = 0;
            end else if (dbg_req) begin
                if (!cpu_req || (STARVE && m_wait >= LIM)) begin
                    m_acc = 1;
                    m_wait = 0;
                end else if (STARVE && m_wait < LIM) begin
                    m_wait++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    int stalls;
    int first_stall;

    initial begin
        n_chk = 0; n_pass = 0;
        m_acc = 0; m_ack = 0; m_wait = 0; m_rdata = 32'd0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'd0;
        fill = 1'b1;
        clrn = 1'b0;
        set_cpu(0, 0, 32'd0, 32'd0);
        set_dbg(0, 0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        fill = 1'b0;
        cycle();
        chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        clrn = 1'b1;

        // CPU store then load of 0x40.
        set_cpu(1, 1, 32'h40, 32'hDEAD_BEEF);
        settle();
        chk("st_addr", 32'(mem_addr), 32'h10);
        tick();
        set_cpu(1, 0, 32'h40, 32'd0);
        settle();
        chk("ld_addr", 32'(mem_addr), 32'h10);
        chk("ld_data", cpu_rdata, 32'hDEAD_BEEF);
        tick();

        // Debug write with CPU idle.
        set_cpu(0, 0, 32'h0, 32'd0);
        set_dbg(1, 1, 32'h80, 32'h1234_5678);
        cycle();
        settle();
        chk("dw_we", 32'(mem_we), 32'd1);
        chk("dw_addr", 32'(mem_addr), 32'h20);
        tick();
        cycle();
        settle();
        chk("dw_ack", 32'(dbg_ack), 32'd1);
        tick();
        set_dbg(0, 0, 32'h0, 32'd0);
        cycle();
        cycle();

        // Debug read of the same word.
        set_dbg(1, 0, 32'h80, 32'd0);
        cycle();
        cycle();
        settle();
        chk("dr_ack", 32'(dbg_ack), 32'd1);
        chk("dr_data", dbg_rdata, 32'h1234_5678);
        tick();
        set_dbg(0, 0, 32'h0, 32'd0);
        cycle();
        cycle();

        // Simultaneous CPU and debug request: CPU first.
        set_cpu(1, 0, 32'h40, 32'd0);
        set_dbg(1, 0, 32'h80, 32'd0);
        settle();
        chk("col_stall", 32'(cpu_stall), 32'd0);
        chk("col_addr", 32'(mem_addr), 32'h10);
        tick();
        set_cpu(0, 0, 32'h0, 32'd0);
        cycle();
        cycle();
        cycle();
        set_dbg(0, 0, 32'h0, 32'd0);
        cycle();
        cycle();

        // CPU holds the port while debug waits.
        stalls = 0;
        first_stall = -1;
        set_cpu(1, 0, 32'h40, 32'd0);
        set_dbg(1, 0, 32'h84, 32'd0);
        for (int i = 0; i < 10; i++) begin
            settle();
            if (cpu_stall) begin
                stalls++;
                if (first_stall < 0) first_stall = i;
            end
            tick();
        end
        chk("stv_stalls", 32'(stalls), STARVE ? 32'd1 : 32'd0);
        chk("stv_first", 32'(first_stall), STARVE ? 32'(LIM + 1) : 32'hFFFF_FFFF);
        set_cpu(0, 0, 32'h0, 32'd0);
        cycle();
        cycle();
        cycle();
        set_dbg(0, 0, 32'h0, 32'd0);
        cycle();
        cycle();

        // Reset during the debug access cycle.
        set_dbg(1, 1, 32'h88, 32'hAAAA_5555);
        cycle();
        settle();
        chk("ra_cs", 32'(mem_cs), 32'd1);
        clrn = 1'b0;
        tick();
        settle();
        chk("ra_ack", 32'(dbg_ack), 32'd0);
        tick();
        set_dbg(0, 0, 32'h0, 32'd0);
        clrn = 1'b1;
        cycle();
        cycle();

        // Random traffic with four-phase debug handshakes.
        for (int i = 0; i < 400; i++) begin
            clrn = ($urandom_range(0, 49) != 0);
            set_cpu($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                    ($urandom() & 32'hFFFF_0003) |
                    (32'($urandom_range(0, 15)) << 2),
                    $urandom());
            if (!dbg_req) begin
                if ($urandom_range(0, 9) < 3) begin
                    set_dbg(1, 1'($urandom_range(0, 1)),
                            ($urandom() & 32'hFFFF_0003) |
                            (32'($urandom_range(0, 15)) << 2),
                            $urandom());
                end
            end else if (m_ack && ($urandom_range(0, 1) == 1)) begin
                dbg_req = 1'b0;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive blocked debug-request cycles before a forced debug grant, legal range 1..255.
REQ-002 Parameter A_WIDTH, default 14: word-address width passed to the data memory.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port clrn, input, 1: reset, synchronous, active-low.
REQ-005 Port cpu_req, input, 1: MEM-stage access to the data-memory region (decoder select for data memory).
REQ-006 Port cpu_we, input, 1: MEM-stage store enable (mwmem).
REQ-007 Port cpu_addr, input, 32: MEM-stage byte address (mal).
REQ-008 Port cpu_wdata, input, 32: MEM-stage store data (md).
REQ-009 Port cpu_rdata, output, 32: load data returned to the MEM stage.
REQ-010 Port cpu_stall, output, 1: freezes the pipeline while the memory port serves debug.
REQ-011 Port dbg_req, input, 1: debug request, four-phase, held until dbg_ack is seen.
REQ-012 Port dbg_we, dbg_addr (32), dbg_wdata (32), inputs: debug transfer, stable while dbg_req=1.
REQ-013 Port dbg_rdata, output, 32: registered debug read data, valid while dbg_ack=1.
REQ-014 Port dbg_ack, output, 1: debug completion, high from the cycle after the access until dbg_req falls.
REQ-015 Ports mem_cs, mem_we (outputs, 1), mem_addr (output, A_WIDTH), mem_wdata (output, 32): memory command.
REQ-016 Port mem_rdata, input, 32: memory read data, combinational (zero read delay).

Function
REQ-017 FSM states: IDLE, DBG_ACC, DBG_ACK; one state register.
REQ-018 In IDLE the port belongs to the CPU: mem_cs=cpu_req, mem_we=cpu_req&cpu_we, mem_addr=cpu_addr[A_WIDTH+1:2], mem_wdata=cpu_wdata, cpu_rdata=mem_rdata, same cycle.
REQ-019 IDLE->DBG_ACC when dbg_req=1 and (cpu_req=0 or the starvation counter has reached STARVE_LIMIT).
REQ-020 In DBG_ACC the port drives debug: mem_cs=1, mem_we=dbg_we, mem_addr=dbg_addr[A_WIDTH+1:2], mem_wdata=dbg_wdata; dbg_rdata is captured from mem_rdata at the end of the cycle; cpu_stall=cpu_req; next state is DBG_ACK.
REQ-021 In DBG_ACK the port returns to the CPU as in IDLE; dbg_ack=1; the block stays in DBG_ACK until dbg_req=0, then goes to IDLE. No second debug access happens without dbg_req returning low.
REQ-022 cpu_stall is 0 in IDLE and DBG_ACK; a stalled CPU access is completed in the following cycle, so a CPU store is never lost or issued twice.
REQ-023 cpu_rdata=0 in DBG_ACC.
REQ-024 If cpu_req and dbg_req both rise in the same cycle, the CPU wins.
REQ-025 Debug inputs are ignored in DBG_ACK.

Reset
REQ-026 While clrn=0 at a clock edge, the following apply: state=IDLE, dbg_ack=0, dbg_rdata=0, starvation counter=0.
REQ-027 While clrn=0, mem_cs=0 and mem_we=0 are forced; cpu_stall=0 is forced.
REQ-028 Reset during DBG_ACC aborts the access; no dbg_ack is issued for it.

Configuration
REQ-029 Macro DMEM_ARB_STARVE_EN.
REQ-030 With DMEM_ARB_STARVE_EN defined:
- An 8-bit counter increments each IDLE cycle with dbg_req=1 and cpu_req=1, saturating at STARVE_LIMIT.
- The counter clears on entry to DBG_ACC.
- Reaching STARVE_LIMIT forces IDLE->DBG_ACC.
REQ-031 Without DMEM_ARB_STARVE_EN, no counter exists and debug is granted only in cycles with cpu_req=0.

Structure
REQ-032 A shared package holds the state encoding (IDLE=2'd0, DBG_ACC=2'd1, DBG_ACK=2'd2) and the default STARVE_LIMIT constant.
REQ-033 One sub-module, dmem_arb_starve_ctr, holds the saturating counter; it is instantiated only under DMEM_ARB_STARVE_EN.

Verification
REQ-034 CPU-only store: cpu_req=1, cpu_we=1, cpu_addr=0x40, cpu_wdata=0xDEADBEEF, then load 0x40 -> mem_addr=0x10 both cycles, cpu_rdata=0xDEADBEEF, cpu_stall never 1.
REQ-035 Debug write with CPU idle: dbg_req=1, dbg_we=1, dbg_addr=0x80, dbg_wdata=0x12345678 -> DBG_ACC next cycle with mem_we=1 and mem_addr=0x20, then dbg_ack=1 until dbg_req drops.
REQ-036 Collision: cpu_req and dbg_req rise together -> CPU access served first, cpu_stall=0 in that cycle.
REQ-037 Starvation with macro, STARVE_LIMIT=4, cpu_req held at 1:
- Debug access occurs after 4 blocked cycles.
- cpu_stall=1 for exactly 1 cycle.
- The CPU access repeats the next cycle.
Without the macro, no debug access occurs while cpu_req=1.
REQ-038 Debug read of 0x80 after REQ-035 -> dbg_rdata=0x12345678 while dbg_ack=1.
REQ-039 Reset: clrn=0 asserted in DBG_ACC -> next cycle state=IDLE, dbg_ack=0, mem_cs=0, cpu_stall=0.
